mainfsm: RTL and testbench

Main state machine of the multicycle controller. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and the raw enables (NextPC, RegW, MemW, Branch) that feed condlogic and the PC-source logic. Outputs are Moore, decoded from state only. condlogic gates them with its one-cycle-delayed CondEx.

---
 rtl/mainfsm_pkg.sv | 48 ++++
 rtl/mainfsm_if.sv | 33 +++
 rtl/mainfsm_outdec.sv | 80 ++++++++
 rtl/mainfsm.sv | 78 +++++++
 tb/tb_mainfsm.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multicycle main controller:
// state codes, datapath select codes, op classes and the control word.
package mainfsm_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_UNKNOWN  = 4'd10;

  localparam logic [1:0] SRCA_RD1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_ZERO = '0;

endpackage

// File: rtl/mainfsm_if.sv
// Instruction fields in, datapath control word out.
// master = controller side, slave = datapath side.
interface mainfsm_if #(
  parameter int STATE_W = 4
);
  logic [1:0]         Op;
  logic [5:0]         Funct;
  logic               IRWrite;
  logic               AdrSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic               ALUOp;
  logic               NextPC;
  logic               RegW;
  logic               MemW;
  logic               Branch;
  logic [STATE_W-1:0] State;

  modport master (
    input  Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
    output ResultSrc, ALUOp, NextPC,
    output RegW, MemW, Branch, State
  );

  modport slave (
    output Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
    input  ResultSrc, ALUOp, NextPC,
    input  RegW, MemW, Branch, State
  );
endinterface

// File: rtl/mainfsm_outdec.sv
// Moore output decoder: state code to control word.
// Unreachable codes fall into the all-zero default.
module mainfsm_outdec
  import mainfsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  localparam logic [STATE_W-1:0] FETCH    = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] DECODE   = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(S_MEMADR);
  localparam logic [STATE_W-1:0] MEMRD    = STATE_W'(S_MEMRD);
  localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(S_MEMWB);
  localparam logic [STATE_W-1:0] MEMWR    = STATE_W'(S_MEMWR);
  localparam logic [STATE_W-1:0] EXECUTER = STATE_W'(S_EXECUTER);
  localparam logic [STATE_W-1:0] EXECUTEI = STATE_W'(S_EXECUTEI);
  localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(S_ALUWB);
  localparam logic [STATE_W-1:0] BRANCH   = STATE_W'(S_BRANCH);

  always_comb begin
    ctrl = CTRL_ZERO;
    unique case (state)
      FETCH: begin
        ctrl.irwrite   = 1'b1;
        ctrl.nextpc    = 1'b1;
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURES;
      end
      // PC+8 is formed here for reads of R15
      DECODE: begin
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURES;
      end
      MEMADR: begin
        ctrl.alusrca = SRCA_RD1;
        ctrl.alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regw      = 1'b1;
      end
      MEMWR: begin
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.memw      = 1'b1;
      end
      EXECUTER: begin
        ctrl.alusrca = SRCA_RD1;
        ctrl.alusrcb = SRCB_RD2;
        ctrl.aluop   = 1'b1;
      end
      EXECUTEI: begin
        ctrl.alusrca = SRCA_RD1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = 1'b1;
      end
      ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regw      = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca   = SRCA_ALUOUT;
        ctrl.alusrcb   = SRCB_IMM;
        ctrl.resultsrc = RES_ALURES;
        ctrl.branch    = 1'b1;
      end
      default: ctrl = CTRL_ZERO;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main controller: state register and next-state logic.
// Outputs are decoded from state alone by mainfsm_outdec.
module mainfsm
  import mainfsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  mainfsm_if.master  bus
);

  localparam logic [STATE_W-1:0] FETCH    = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] DECODE   = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(S_MEMADR);
  localparam logic [STATE_W-1:0] MEMRD    = STATE_W'(S_MEMRD);
  localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(S_MEMWB);
  localparam logic [STATE_W-1:0] MEMWR    = STATE_W'(S_MEMWR);
  localparam logic [STATE_W-1:0] EXECUTER = STATE_W'(S_EXECUTER);
  localparam logic [STATE_W-1:0] EXECUTEI = STATE_W'(S_EXECUTEI);
  localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(S_ALUWB);
  localparam logic [STATE_W-1:0] BRANCH   = STATE_W'(S_BRANCH);
  localparam logic [STATE_W-1:0] UNKNOWN  = STATE_W'(S_UNKNOWN);

  logic [STATE_W-1:0] st_q;
  logic [STATE_W-1:0] st_d;
  ctrl_t              ctrl;
  logic               unused_funct;

  assign unused_funct = ^bus.Funct[4:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_q <= FETCH;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = FETCH;
    unique case (st_q)
      FETCH: st_d = DECODE;
      DECODE: begin
        unique case (bus.Op)
          OP_MEM:  st_d = MEMADR;
          OP_BR:   st_d = BRANCH;
          OP_DP:   st_d = bus.Funct[5] ? EXECUTEI
                                       : EXECUTER;
          default: st_d = UNKNOWN;
        endcase
      end
      MEMADR:   st_d = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    st_d = MEMWB;
      EXECUTER: st_d = ALUWB;
      EXECUTEI: st_d = ALUWB;
      // every other state, reachable or not, returns to fetch
      default:  st_d = FETCH;
    endcase
  end

  mainfsm_outdec #(
    .STATE_W (STATE_W)
  ) u_outdec (
    .state (st_q),
    .ctrl  (ctrl)
  );

  assign bus.IRWrite   = ctrl.irwrite;
  assign bus.AdrSrc    = ctrl.adrsrc;
  assign bus.ALUSrcA   = ctrl.alusrca;
  assign bus.ALUSrcB   = ctrl.alusrcb;
  assign bus.ResultSrc = ctrl.resultsrc;
  assign bus.ALUOp     = ctrl.aluop;
  assign bus.NextPC    = ctrl.nextpc;
  assign bus.RegW      = ctrl.regw;
  assign bus.MemW      = ctrl.memw;
  assign bus.Branch    = ctrl.branch;
  assign bus.State     = st_q;

endmodule

// File: tb/tb_mainfsm.sv
// Bench for mainfsm: directed instruction classes, async abort,
// then random instructions against a path/control-word model.
module tb_mainfsm;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mainfsm_if #(.STATE_W(4)) bus ();

  mainfsm #(
    .STATE_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch}
  function automatic logic [12:0] exp_ctrl(input int s);
    case (s)
      0:  return 13'b1_0_01_10_10_0_1_0_0_0;
      1:  return 13'b0_0_01_10_10_0_0_0_0_0;
      2:  return 13'b0_0_00_01_00_0_0_0_0_0;
      3:  return 13'b0_1_00_00_00_0_0_0_0_0;
      4:  return 13'b0_0_00_00_01_0_0_1_0_0;
      5:  return 13'b0_1_00_00_00_0_0_0_1_0;
      6:  return 13'b0_0_00_00_00_1_0_0_0_0;
      7:  return 13'b0_0_00_01_00_1_0_0_0_0;
      8:  return 13'b0_0_00_00_00_0_0_1_0_0;
      9:  return 13'b0_0_10_01_10_0_0_0_0_1;
      default: return 13'b0;
    endcase
  endfunction

  function automatic logic [12:0] obs_ctrl();
    return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA,
            bus.ALUSrcB, bus.ResultSrc, bus.ALUOp,
            bus.NextPC, bus.RegW, bus.MemW, bus.Branch};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_state(input int s);
    chk($sformatf("state@%0d", s), 32'(bus.State), 32'(s));
    chk($sformatf("ctrl@%0d", s), 32'(obs_ctrl()),
        32'(exp_ctrl(s)));
  endtask

  // Visit order of one instruction, from the class latencies.
  task automatic run_instr(input logic [1:0] op,
                           input logic [5:0] f,
                           input int abort_at);
    int seq[$];
    case (op)
      2'b00:   seq = f[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
      2'b01:   seq = f[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b10:   seq = '{0, 1, 9};
      default: seq = '{0, 1, 10};
    endcase
    foreach (seq[i]) begin
      chk_state(seq[i]);
      if (seq[i] == 1 || seq[i] == 2) begin
        bus.Op    = op;
        bus.Funct = f;
      end else begin
        bus.Op    = 2'($urandom);
        bus.Funct = 6'($urandom);
      end
      if (seq[i] == abort_at) begin
        #2 reset = 1'b1;
        #1;
        chk("abort_state", 32'(bus.State), 32'd0);
        chk("abort_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0)));
        @(negedge clk);
        chk("abort_regw", 32'(bus.RegW), 32'd0);
        chk("abort_memw", 32'(bus.MemW), 32'd0);
        reset = 1'b0;
        #1;
        return;
      end
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    logic [1:0] op;
    logic [5:0] f;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.Op    = 2'b00;
    bus.Funct = 6'b0;

    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_state", 32'(bus.State), 32'd0);
      chk("rst_irwrite", 32'(bus.IRWrite), 32'd1);
      chk("rst_nextpc", 32'(bus.NextPC), 32'd1);
    end
    reset = 1'b0;
    #1;
    chk("rel_state", 32'(bus.State), 32'd0);
    chk("rel_alusrcb", 32'(bus.ALUSrcB), 32'd2);
    chk("rel_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0)));

    run_instr(2'b00, 6'b000100, -1);
    run_instr(2'b00, 6'b100100, -1);
    run_instr(2'b01, 6'b011001, -1);
    run_instr(2'b01, 6'b011000, -1);
    run_instr(2'b10, 6'b101010, -1);
    run_instr(2'b11, 6'b111111, -1);
    run_instr(2'b01, 6'b011001, 3);
    run_instr(2'b01, 6'b011000, -1);

    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom);
      f  = 6'($urandom);
      run_instr(op, f, ($urandom_range(0, 15) == 0) ? 2 : -1);
    end
    chk_state(0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
